// File: rtl/icache_inst_feeder.sv
// icache_inst_feeder: buffers driver instruction words and feeds one per core fetch, inserting NOPs when empty.
// Holds the core for a fixed wake period after reset and again while starved of instructions.
module icache_inst_feeder #(
  parameter int          DEPTH        = 8,
  parameter logic [31:0] NOP_INST     = 32'h01000000,
  parameter int          RESET_STALL  = 4,
  parameter int          STARVE_LIMIT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [31:0]                in_inst,
  output logic                       in_ready,
  input  logic                       fetch_req,
  input  logic [31:0]                fetch_addr,
  input  logic                       flush,
  output logic [31:0]                ico_data,
  output logic                       ico_hold,
  output logic                       trace_valid,
  output logic [31:0]                trace_addr,
  output logic [31:0]                trace_inst,
  output logic                       trace_nop,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       starved
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(RESET_STALL + 1);
  localparam int NW = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] WAKE = 2'd0, RUN = 2'd1, STARVED = 2'd2;

  logic [31:0]   r_mem [DEPTH];
  logic [AW:0]   r_wp, r_rp;
  logic [1:0]    r_state;
  logic [SW-1:0] r_stall;
  logic [NW-1:0] r_nops;
  logic          r_hold, r_starved, r_tvalid, r_tnop;
  logic [31:0]   r_data, r_taddr, r_tinst;

  logic [AW:0]   w_level;
  logic          w_full, w_empty, w_push, w_issue, w_pop;
  logic [31:0]   w_word;
  logic [NW-1:0] w_nops_inc;

  // flush wins over both a same-cycle push and pop
  assign w_level    = r_wp - r_rp;
  assign w_full     = w_level == (AW+1)'(DEPTH);
  assign w_empty    = w_level == '0;
  assign w_push     = in_valid && !w_full && !flush;
  assign w_issue    = r_state == RUN && fetch_req;
  assign w_pop      = w_issue && !w_empty && !flush;
  assign w_word     = w_pop ? r_mem[r_rp[AW-1:0]] : NOP_INST;
  assign w_nops_inc = r_nops + 1'b1;

  assign in_ready    = !w_full;
  assign level       = w_level;
  assign ico_data    = r_data;
  assign ico_hold    = r_hold;
  assign trace_valid = r_tvalid;
  assign trace_addr  = r_taddr;
  assign trace_inst  = r_tinst;
  assign trace_nop   = r_tnop;
  assign starved     = r_starved;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= in_inst;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (flush) begin
      r_rp <= r_wp;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= WAKE;
      r_stall   <= SW'(RESET_STALL);
      r_nops    <= '0;
      r_hold    <= 1'b0;
      r_starved <= 1'b0;
      r_data    <= NOP_INST;
      r_tvalid  <= 1'b0;
      r_taddr   <= '0;
      r_tinst   <= '0;
      r_tnop    <= 1'b0;
    end else begin
      r_tvalid <= w_issue;
      if (w_issue) begin
        r_data  <= w_word;
        r_taddr <= fetch_addr;
        r_tinst <= w_word;
        r_tnop  <= !w_pop;
        r_nops  <= w_pop ? '0 : w_nops_inc;
      end
      case (r_state)
        WAKE: begin
          r_stall <= r_stall - 1'b1;
          if (r_stall == SW'(1)) begin
            r_state <= RUN;
            r_hold  <= 1'b1;
          end
        end
        RUN:
          if (w_issue && !w_pop && w_nops_inc == NW'(STARVE_LIMIT)) begin
            r_state   <= STARVED;
            r_hold    <= 1'b0;
            r_starved <= 1'b1;
          end
        STARVED:
          if (!w_empty) begin
            r_state   <= RUN;
            r_hold    <= 1'b1;
            r_starved <= 1'b0;
            r_nops    <= '0;
          end
        default: r_state <= WAKE;
      endcase
    end
endmodule

// File: doc/icache_inst_feeder.md
Name: icache_inst_feeder

Overview:
Instruction-side feeder that sits directly upstream of the LEON integer-unit interface. It buffers instruction words pushed by the testbench driver in a FIFO and presents one word per core fetch on the icache-output data/hold lines. When the FIFO is empty it inserts SPARC NOPs, and it stalls the core after reset or after prolonged starvation. It emits a per-fetch trace (address and word) for the scoreboard.

Parameters:
DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.
NOP_INST, 32'h01000000, word issued when no instruction is buffered.
RESET_STALL, 4, cycles the core is held after reset release; must be at least 1.
STARVE_LIMIT, 16, consecutive inserted NOPs before entering STARVED; must be at least 1.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  reset, asynchronous, active-high.
in_valid  in  1  driver offers in_inst.
in_inst  in  32  instruction word from driver.
in_ready  out  1  FIFO can accept; equals !full (combinational from count).
fetch_req  in  1  core requests the next instruction this cycle.
fetch_addr  in  32  fetch address from the core's icache input.
flush  in  1  discard all buffered instructions.
ico_data  out  32  instruction to the core (registered).
ico_hold  out  1  LEON convention: 1 = run, 0 = hold the core (registered).
trace_valid  out  1  one-cycle pulse per issued word.
trace_addr  out  32  fetch_addr sampled at the issuing fetch.
trace_inst  out  32  word issued (equals ico_data).
trace_nop  out  1  issued word was an inserted NOP.
level  out  $clog2(DEPTH)+1  current FIFO occupancy.
starved  out  1  high while in STARVED.

Behaviour:
- Reset (async assert, sync release): FIFO empty, level=0, ico_data=NOP_INST, ico_hold=0, all trace_* = 0, starved=0, stall counter=RESET_STALL, consecutive-NOP counter=0, state=WAKE.
- FIFO: read/write pointers are log2(DEPTH)+1 bits; wrap-around is natural modulo.
  - full when level==DEPTH; empty when level==0.
  - A push occurs when in_valid && in_ready.
  - A push while full is impossible, because in_ready=0 even if a pop happens in the same cycle.
  - No bypass: a push and a fetch in the same cycle on an empty FIFO issue a NOP; the pushed word is issued on the next fetch.
- FSM, state WAKE:
  - ico_hold=0.
  - Counter decrements each cycle; at 0 the FSM moves to RUN and ico_hold=1 on that edge.
  - fetch_req is ignored in WAKE.
  - Pushes are accepted.
- FSM, state RUN, on each cycle with fetch_req=1:
  - If not empty: pop the head; on the next edge ico_data=head, trace_nop=0, and the NOP counter clears.
  - If empty: ico_data=NOP_INST, trace_nop=1, and the NOP counter increments.
  - In both cases trace_valid=1, trace_addr=fetch_addr, trace_inst=new ico_data.
  - Latency: exactly 1 cycle from the fetch_req sample to ico_data/trace.
  - With fetch_req=0, ico_data holds its value and trace_valid=0.
- RUN to STARVED: when an inserted NOP makes the counter equal STARVE_LIMIT, the FSM enters STARVED on that edge, with ico_hold=0 and starved=1.
- FSM, state STARVED:
  - ico_hold=0; fetch_req is ignored; no pops.
  - When level becomes non-zero, the FSM returns to RUN on the next edge, with ico_hold=1, starved=0 and the counter cleared.
- flush: synchronous.
  - Empties the FIFO and sets level=0.
  - Has priority over a same-cycle push (the word is dropped) and a same-cycle pop (a NOP is issued, trace_nop=1).
  - Does not change the FSM state and does not reset the NOP counter.
- Reset mid-operation: immediate return to the reset values; buffered words are lost and no trace pulse is produced.

Test Plan:
1. Reset, release, idle -> ico_hold=0 for 4 cycles then 1; ico_data=32'h01000000; trace_valid never pulses.
2. Push 32'h82004002, 32'h82006004, 32'h82008006, then 3 consecutive fetch_req with fetch_addr 0x40000000/4/8 -> the 3 words appear one cycle after each fetch, with matching trace_addr and trace_nop=0.
3. No pushes, 16 fetches -> 16 NOPs with trace_nop=1, then starved=1 and ico_hold=0; push one word -> next edge ico_hold=1, and the next fetch issues that word.
4. Push 9 words with no fetches -> 8 accepted, in_ready=0, level=8; one fetch -> in_ready returns to 1 the cycle after the pop.
5. level=5 with flush, push and fetch in the same cycle -> level=0, issued word 32'h01000000 with trace_nop=1, pushed word never issued.
6. Assert rst with level=3 mid-stream -> all outputs return to reset values asynchronously; no pre-reset word is issued after the WAKE period.
